// File: rtl/vend_pkg.sv
// Shared definitions between the coin acceptor and the vending FSM:
// coin bus encoding and the acceptor state set.
package vend_pkg;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_NICKEL = 2'b01;
    localparam logic [1:0] COIN_DIME   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUAL,
        ST_WAIT_REL,
        ST_EMIT,
        ST_GAP,
        ST_JAM
    } acc_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for the asynchronous coin sensors.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin mechanism front end: debounces the nickel/dime sensors, validates pulse
// width and emits one registered coin code per coin, with reject and jam flags.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int MAX_WIDTH  = 64,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nickel_sense,
    input  logic             dime_sense,
    input  logic             coke,
    output logic [1:0]       coin,
    output logic             reject,
    output logic             jam,
    output logic [CNT_W-1:0] coin_count
);

    localparam int WCNT_W = $clog2(MAX_WIDTH + 2);
    localparam int JCNT_W = $clog2(DEB_CYCLES + 1);
    localparam int GCNT_W = $clog2(GAP_CYCLES + 1);

    logic              ns;
    logic              ds;
    acc_state_t        state;
    logic              is_dime;
    logic              armed;
    logic [1:0]        fill;
    logic              rej_pend;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_next;
    logic [JCNT_W-1:0] jcnt;
    logic [GCNT_W-1:0] gcnt;
    logic              lat;
    logic              oth;

    sync_2ff u_sync_nickel (.clk(clk), .rst(rst), .d(nickel_sense), .q(ns));
    sync_2ff u_sync_dime   (.clk(clk), .rst(rst), .d(dime_sense),   .q(ds));

    assign lat       = is_dime ? ds : ns;
    assign oth       = is_dime ? ns : ds;
    assign wcnt_next = wcnt + 1'b1;

    // Arming waits until the synchroniser holds real samples, so a coin left in
    // the chute across reset is seen as high and never credited.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            coin       <= COIN_NONE;
            reject     <= 1'b0;
            jam        <= 1'b0;
            coin_count <= '0;
            is_dime    <= 1'b0;
            armed      <= 1'b0;
            fill       <= 2'd0;
            rej_pend   <= 1'b0;
            wcnt       <= '0;
            jcnt       <= '0;
            gcnt       <= '0;
        end else begin
            coin   <= COIN_NONE;
            reject <= 1'b0;
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end else if (!ns && !ds) begin
                armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (armed && ns && ds) begin
                        state <= ST_JAM;
                        jam   <= 1'b1;
                        jcnt  <= '0;
                    end else if (armed && (ns || ds)) begin
                        state   <= ST_QUAL;
                        is_dime <= ds;
                        wcnt    <= WCNT_W'(1);
                    end
                end
                ST_QUAL: begin
                    if (!lat) begin
                        state <= ST_IDLE;
                    end else if (oth) begin
                        state <= ST_JAM;
                        jam   <= 1'b1;
                        jcnt  <= '0;
                    end else begin
                        wcnt <= wcnt_next;
                        if (wcnt_next == WCNT_W'(DEB_CYCLES)) begin
                            state <= ST_WAIT_REL;
                        end
                    end
                end
                ST_WAIT_REL: begin
                    if (oth) begin
                        state <= ST_JAM;
                        jam   <= 1'b1;
                        jcnt  <= '0;
                    end else if (!lat) begin
                        gcnt <= '0;
                        if (coke) begin
                            state    <= ST_GAP;
                            rej_pend <= 1'b1;
                        end else begin
                            state <= ST_EMIT;
                        end
                    end else begin
                        wcnt <= wcnt_next;
                        if (wcnt_next > WCNT_W'(MAX_WIDTH)) begin
                            state <= ST_JAM;
                            jam   <= 1'b1;
                            jcnt  <= '0;
                        end
                    end
                end
                ST_EMIT: begin
                    coin       <= is_dime ? COIN_DIME : COIN_NICKEL;
                    coin_count <= coin_count + 1'b1;
                    state      <= ST_GAP;
                    gcnt       <= '0;
                end
                // A refused coin raises reject on the first GAP cycle, which keeps
                // its timing identical to an accepted coin's code.
                ST_GAP: begin
                    reject   <= rej_pend;
                    rej_pend <= 1'b0;
                    if (gcnt == GCNT_W'(GAP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                ST_JAM: begin
                    if (ns || ds) begin
                        jcnt <= '0;
                    end else if (jcnt == JCNT_W'(DEB_CYCLES - 1)) begin
                        state <= ST_GAP;
                        gcnt  <= '0;
                        jam   <= 1'b0;
                    end else begin
                        jcnt <= jcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomised self-checking bench for coin_acceptor; outcomes are predicted from
// pulse length, sensor mix and coke at release.
module tb_coin_acceptor;

    localparam int DEB  = 4;
    localparam int MAXW = 64;
    localparam int GAP  = 2;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          nickel_sense;
    logic          dime_sense;
    logic          coke;
    logic [1:0]    coin;
    logic          reject;
    logic          jam;
    logic [CW-1:0] coin_count;

    int checks = 0;
    int errors = 0;
    int codes_seen = 0;
    int rejects_seen = 0;
    int zero_run = 100;
    int exp_count = 0;

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEB_CYCLES(DEB),
        .MAX_WIDTH (MAXW),
        .GAP_CYCLES(GAP),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .nickel_sense(nickel_sense),
        .dime_sense  (dime_sense),
        .coke        (coke),
        .coin        (coin),
        .reject      (reject),
        .jam         (jam),
        .coin_count  (coin_count)
    );

    // Advance one clock and watch the bus rules that must hold on every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) begin
            checks++;
            if (coin === 2'b11) begin
                errors++;
                $display("FAIL bus_code coin got %b want not 11", coin);
            end
            checks++;
            if (coin !== 2'b00 && reject === 1'b1) begin
                errors++;
                $display("FAIL coin_and_reject coin got %b reject got %b want one of them idle", coin, reject);
            end
            if (coin !== 2'b00) begin
                codes_seen++;
                checks++;
                if (zero_run < GAP) begin
                    errors++;
                    $display("FAIL code_gap idle cycles got %0d want >= %0d", zero_run, GAP);
                end
                zero_run = 0;
            end else begin
                zero_run++;
            end
            if (reject === 1'b1) rejects_seen++;
        end
    endtask

    task automatic apply_reset(input logic [1:0] sens);
        rst          = 1'b1;
        nickel_sense = sens[0];
        dime_sense   = sens[1];
        coke         = 1'b0;
        repeat (3) tick();
        checks++;
        if (coin !== 2'b00 || reject !== 1'b0 || jam !== 1'b0 || coin_count !== '0) begin
            errors++;
            $display("FAIL reset_state got coin=%b reject=%b jam=%b count=%0d want 00 0 0 0",
                     coin, reject, jam, coin_count);
        end
        rst       = 1'b0;
        exp_count = 0;
        zero_run  = 100;
    endtask

    // Drive one sensor pulse of len sampled-high cycles and check the predicted outcome.
    task automatic run_pulse(input logic [1:0] sens, input int len, input logic coke_v, input string tag);
        int         kind;
        int         c0;
        int         r0;
        logic [1:0] exp_code;
        logic       jam_seen;
        if (sens == 2'b11)      kind = 3;
        else if (len < DEB)     kind = 0;
        else if (len > MAXW)    kind = 3;
        else if (coke_v)        kind = 2;
        else                    kind = 1;
        exp_code = sens[1] ? 2'b10 : 2'b01;
        c0 = codes_seen;
        r0 = rejects_seen;
        jam_seen = 1'b0;

        nickel_sense = sens[0];
        dime_sense   = sens[1];
        for (int i = 0; i < len; i++) begin
            coke = 1'($urandom_range(0, 1));
            tick();
            if (jam === 1'b1) jam_seen = 1'b1;
        end
        nickel_sense = 1'b0;
        dime_sense   = 1'b0;
        coke         = coke_v;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (jam === 1'b1) jam_seen = 1'b1;
        end
        checks++;
        if (coin !== 2'b00 || reject !== 1'b0) begin
            errors++;
            $display("FAIL %s early_output got coin=%b reject=%b want 00 0", tag, coin, reject);
        end
        tick();
        checks++;
        if (coin !== (kind == 1 ? exp_code : 2'b00)) begin
            errors++;
            $display("FAIL %s coin_latency got %b want %b", tag, coin, (kind == 1 ? exp_code : 2'b00));
        end
        checks++;
        if (reject !== (kind == 2)) begin
            errors++;
            $display("FAIL %s reject_latency got %b want %b", tag, reject, (kind == 2));
        end
        tick();
        checks++;
        if (coin !== 2'b00 || jam !== (kind == 3)) begin
            errors++;
            $display("FAIL %s after_code got coin=%b jam=%b want 00 %b", tag, coin, jam, (kind == 3));
        end
        if (jam === 1'b1) jam_seen = 1'b1;
        tick();
        checks++;
        if (jam !== 1'b0) begin
            errors++;
            $display("FAIL %s jam_release got %b want 0", tag, jam);
        end
        coke = 1'b0;
        repeat (4) tick();

        if (kind == 1) exp_count = (exp_count + 1) % (1 << CW);
        checks++;
        if (coin_count !== CW'(exp_count)) begin
            errors++;
            $display("FAIL %s coin_count got %0d want %0d", tag, coin_count, exp_count);
        end
        checks++;
        if (codes_seen - c0 !== int'(kind == 1) || rejects_seen - r0 !== int'(kind == 2)) begin
            errors++;
            $display("FAIL %s event_count got codes=%0d rejects=%0d want %0d %0d",
                     tag, codes_seen - c0, rejects_seen - r0, int'(kind == 1), int'(kind == 2));
        end
        checks++;
        if (jam_seen !== (kind == 3)) begin
            errors++;
            $display("FAIL %s jam_seen got %b want %b", tag, jam_seen, (kind == 3));
        end
    endtask

    task automatic test_reset();
        apply_reset(2'b00);
        repeat (4) tick();
    endtask

    task automatic test_nickel();
        run_pulse(2'b01, 10, 1'b0, "nickel_10");
        run_pulse(2'b10, 10, 1'b0, "dime_10");
    endtask

    task automatic test_glitch();
        run_pulse(2'b10, 2, 1'b0, "dime_glitch_2");
        run_pulse(2'b01, DEB - 1, 1'b0, "nickel_deb_minus_1");
        run_pulse(2'b01, DEB, 1'b0, "nickel_deb_exact");
        for (int i = 0; i < 3; i++) begin
            run_pulse(2'($urandom_range(1, 2)), $urandom_range(1, DEB - 1), 1'($urandom_range(0, 1)), "glitch_rand");
        end
    endtask

    task automatic test_simultaneous();
        run_pulse(2'b11, 8, 1'b0, "both_sensors");
        run_pulse(2'b11, 2, 1'b1, "both_short");
    endtask

    task automatic test_reject();
        run_pulse(2'b10, 8, 1'b1, "dime_coke");
        run_pulse(2'b01, DEB, 1'b1, "nickel_coke_deb");
    endtask

    task automatic test_width();
        run_pulse(2'b01, 70, 1'b0, "nickel_70");
        run_pulse(2'b10, MAXW, 1'b0, "dime_max_width");
        run_pulse(2'b10, MAXW + 1, 1'b0, "dime_max_plus_1");
    endtask

    task automatic test_random();
        logic [1:0] sens;
        for (int i = 0; i < 20; i++) begin
            sens = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(1, 2));
            run_pulse(sens, $urandom_range(1, MAXW + 3), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_back_to_back();
        nickel_sense = 1'b1;
        repeat (6) tick();
        nickel_sense = 1'b0;
        coke = 1'b0;
        tick();
        dime_sense = 1'b1;
        repeat (3) tick();
        checks++;
        if (coin !== 2'b01) begin
            errors++;
            $display("FAIL b2b_first got %b want 01", coin);
        end
        repeat (9) tick();
        dime_sense = 1'b0;
        repeat (4) tick();
        checks++;
        if (coin !== 2'b10) begin
            errors++;
            $display("FAIL b2b_second got %b want 10", coin);
        end
        repeat (6) tick();
        exp_count = (exp_count + 2) % (1 << CW);
        checks++;
        if (coin_count !== CW'(exp_count)) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", coin_count, exp_count);
        end
    endtask

    task automatic test_reset_held();
        int c0;
        apply_reset(2'b10);
        c0 = codes_seen;
        repeat (20) tick();
        dime_sense = 1'b0;
        repeat (10) tick();
        checks++;
        if (codes_seen != c0 || coin_count !== '0 || jam !== 1'b0) begin
            errors++;
            $display("FAIL held_through_reset got codes=%0d count=%0d jam=%b want 0 0 0",
                     codes_seen - c0, coin_count, jam);
        end
        run_pulse(2'b10, 10, 1'b0, "fresh_dime");
    endtask

    task automatic test_wrap();
        apply_reset(2'b00);
        repeat (4) tick();
        for (int i = 0; i < 256; i++) begin
            run_pulse(2'b01, $urandom_range(DEB, 8), 1'b0, "wrap");
        end
        checks++;
        if (coin_count !== '0) begin
            errors++;
            $display("FAIL count_wrap got %0d want 0", coin_count);
        end
    endtask

    initial begin
        rst          = 1'b1;
        nickel_sense = 1'b0;
        dime_sense   = 1'b0;
        coke         = 1'b0;
        test_reset();
        test_nickel();
        test_glitch();
        test_simultaneous();
        test_reject();
        test_width();
        test_random();
        test_back_to_back();
        test_reset_held();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front end of the vending machine. Owns the raw coin-mechanism sensors and drives the 2-bit coin code bus consumed by the vending FSM.
- Synchronises and debounces the nickel and dime sensors, and validates pulse width.
- Emits exactly one single-cycle coin code per physical coin, with guaranteed idle gaps between codes.
- Rejects coins that arrive while a vend is in progress, and flags jams.

Parameters:
- DEB_CYCLES, 4: consecutive synced-high cycles needed to qualify a sensor pulse.
- MAX_WIDTH, 64: synced-high cycles beyond which a pulse is a jam.
- GAP_CYCLES, 2: minimum cycles of coin=00 after every emitted code.
- CNT_W, 8: width of coin_count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- nickel_sense  in  1  raw nickel sensor; asynchronous, high while a coin is in the chute.
- dime_sense  in  1  raw dime sensor; asynchronous.
- coke  in  1  vend-in-progress from the vending FSM; inhibits acceptance.
- coin  out  2  coin code: 00 none, 01 nickel, 10 dime; 11 is never driven. Registered.
- reject  out  1  one-cycle pulse when a qualified coin is refused.
- jam  out  1  level; high while in JAM state.
- coin_count  out  CNT_W  total coins emitted; wraps modulo 2^CNT_W.

Behaviour:
- Sync and reset
  - Each sense input passes through a 2-flop synchroniser. All logic uses the synced values (ns, ds).
  - On rst: state=IDLE, coin=00, reject=0, jam=0, coin_count=0, synchronisers=0, counters=0, armed=0.
- Arming
  - armed sets on the first cycle with ns=0 and ds=0. IDLE ignores the sensors while armed=0.
  - A coin sitting in the chute across reset is therefore never credited.
- States: IDLE, QUAL, WAIT_REL, EMIT, GAP, JAM. Every output is registered.
- IDLE
  - armed, exactly one of ns/ds=1 → QUAL. Latch type (nickel/dime); width counter wcnt=1.
  - armed, ns=1 and ds=1 → JAM.
- QUAL
  - Latched sensor drops before wcnt reaches DEB_CYCLES → IDLE. Glitch: no coin, no reject.
  - Other sensor rises → JAM.
  - wcnt==DEB_CYCLES → WAIT_REL.
  - wcnt increments every cycle.
- WAIT_REL
  - wcnt keeps incrementing. wcnt>MAX_WIDTH, or other sensor rises → JAM.
  - Latched sensor low with coke=0 → EMIT.
  - Latched sensor low with coke=1 → GAP, with reject=1 for that one cycle. No code emitted, count unchanged.
- EMIT
  - coin = latched code for exactly one cycle; coin_count+1 (wraps) → GAP.
- GAP
  - coin=00 for GAP_CYCLES cycles, then → IDLE.
  - Sensor activity during GAP is ignored. A sensor still high on GAP exit qualifies from scratch in IDLE.
- JAM
  - jam=1, coin=00.
  - Exit to GAP once ns=0 and ds=0 for DEB_CYCLES consecutive cycles; jam drops on the exit cycle.
  - No code and no reject is ever produced from JAM.
- Latency
  - Latched raw sensor sampled low at edge N → coin code (or reject) is high during the cycle after edge N+3.
- Bus invariants
  - coin is never 11.
  - Two non-zero codes are always separated by ≥ GAP_CYCLES zeros.
  - coin and reject are never high together.
- coke is sampled only in WAIT_REL on the release cycle. coke changing during QUAL has no effect.
- rst mid-operation overrides everything on the next edge. A partially qualified coin is discarded.

Decomposition:
- vend_pkg (shared with the vending FSM) holds:
  - coin code constants COIN_NONE=2'b00, COIN_NICKEL=2'b01, COIN_DIME=2'b10;
  - the acceptor state enum.
- Sub-module sync_2ff: 1-bit two-flop synchroniser, instantiated twice.

Test Plan:
1. DEB=4. nickel_sense high 10 cycles, then low, coke=0 → coin=01 for exactly one cycle, 3 cycles after the fall is sampled; then ≥2 cycles of 00; coin_count=1.
2. dime_sense high 2 cycles → coin stays 00, reject=0, coin_count=0, state returns to IDLE.
3. nickel_sense and dime_sense rise together → jam=1 and coin=00. Both released → jam stays 1 for 4 more cycles, then 0. No code, no reject.
4. dime_sense high 8 cycles, coke=1 at release → reject pulse of 1 cycle, coin stays 00, coin_count unchanged.
5. nickel_sense held 70 cycles (MAX_WIDTH=64) → jam=1 before the release. No code is ever emitted for that coin.
6. dime_sense high at rst deassert, held 20 cycles → no code. After it drops, a fresh 10-cycle dime pulse → coin=10 once, coin_count=1.
7. 256 nickels with CNT_W=8 → coin_count wraps to 0.
